// File: rtl/fir_ctrl.sv
// Sample sequencer and double-buffered coefficient manager for the parallel FIR datapath.
// Optional FIR_CTRL_FLUSH_ON_SWAP_EN: clear the delay line and fill counter on every coefficient swap.
module fir_ctrl #(
  parameter int FIR_LEN  = 21,
  parameter int NB_IN    = 8,
  parameter int NB_COEFF = 8,
  parameter int NB_ADDR  = 5,
  parameter int NB_CNT   = 5
) (
  input  logic                         clk,
  input  logic                         i_reset,
  input  logic                         i_en,
  input  logic [NB_IN-1:0]             i_sample,
  input  logic                         i_sample_valid,
  output logic                         o_sample_ready,
  input  logic                         i_coeff_we,
  input  logic [NB_ADDR-1:0]           i_coeff_addr,
  input  logic [NB_COEFF-1:0]          i_coeff_wdata,
  input  logic                         i_coeff_commit,
  output logic [FIR_LEN*NB_IN-1:0]     o_data_reg,
  output logic [FIR_LEN*NB_COEFF-1:0]  o_coeff,
  output logic                         o_fir_en,
  output logic                         o_fir_valid,
  output logic                         o_out_valid,
  output logic [1:0]                   o_state,
  output logic                         o_coeff_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FILL = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] SWAP = 2'd3;

  localparam int DW = FIR_LEN * NB_IN;
  localparam int CW = FIR_LEN * NB_COEFF;
  localparam logic [NB_ADDR-1:0] LEN_A = NB_ADDR'(FIR_LEN);
  localparam logic [NB_CNT-1:0]  LEN_C = NB_CNT'(FIR_LEN);

  logic [1:0]        state;
  logic [NB_CNT-1:0] cnt;
  logic [NB_CNT-1:0] cnt_next;
  logic [CW-1:0]     shadow;
  logic              pending;
  logic              full_d;
  logic              accept;
  logic              swap_now;

  assign o_sample_ready = i_en && (state != SWAP);
  assign accept         = i_sample_valid && o_sample_ready;
  assign o_state        = state;
  // IDLE has no streaming to protect, so a pending commit is applied straight away.
  assign swap_now       = (state == SWAP) || ((state == IDLE) && pending);

  always_comb begin
    cnt_next = cnt;
    if (accept && (cnt != LEN_C))
      cnt_next = cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      o_data_reg  <= '0;
      cnt         <= '0;
      full_d      <= 1'b0;
      o_out_valid <= 1'b0;
      o_fir_valid <= 1'b0;
      o_fir_en    <= 1'b0;
    end else begin
      o_fir_en    <= i_en;
      o_fir_valid <= accept;
      if (!i_en) begin
        o_data_reg  <= '0;
        cnt         <= '0;
        full_d      <= 1'b0;
        o_out_valid <= 1'b0;
      end else begin
        if (accept)
          o_data_reg <= {o_data_reg[DW-NB_IN-1:0], i_sample};
        cnt         <= cnt_next;
        full_d      <= accept && (cnt_next == LEN_C);
        o_out_valid <= full_d;
`ifdef FIR_CTRL_FLUSH_ON_SWAP_EN
        if (state == SWAP) begin
          o_data_reg <= '0;
          cnt        <= '0;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      state <= IDLE;
    end else if (!i_en) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: state <= FILL;
        FILL: begin
          if (pending)
            state <= SWAP;
          else if (cnt_next == LEN_C)
            state <= RUN;
        end
        RUN: begin
          if (pending)
            state <= SWAP;
        end
        SWAP: begin
`ifdef FIR_CTRL_FLUSH_ON_SWAP_EN
          state <= FILL;
`else
          // The fill count is untouched by a transparent swap, so it identifies the state to resume.
          state <= (cnt == LEN_C) ? RUN : FILL;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      shadow      <= '0;
      o_coeff     <= '0;
      pending     <= 1'b0;
      o_coeff_err <= 1'b0;
    end else begin
      // The swap copies pre-edge shadow contents; a commit arriving on the swap edge merges into it.
      if (swap_now) begin
        o_coeff <= shadow;
        pending <= 1'b0;
      end else if (i_coeff_commit) begin
        pending <= 1'b1;
      end
      if (i_coeff_we) begin
        if (i_coeff_addr < LEN_A) begin
          for (int unsigned k = 0; k < FIR_LEN; k++) begin
            if (i_coeff_addr == NB_ADDR'(k))
              shadow[k*NB_COEFF +: NB_COEFF] <= i_coeff_wdata;
          end
        end else begin
          o_coeff_err <= 1'b1;
        end
      end
    end
  end

endmodule
